ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave that sits directly downstream of the AHB bus interface and turns its address/data-phase traffic into
//  accesses on a synchronous single-port SRAM (1-cycle read latency). Zero-wait-state for reads and writes, except one
//  inserted wait state when a read follows a write back-to-back. Two-cycle ERROR response for illegal transfers.
// PARAMETERS
//  ADDR_WIDTH  32  AHB haddr width
//  DATA_WIDTH  32  AHB hwdata/hrdata width; only 32 is supported
//  MEM_AW      14  SRAM word-address width; memory is 2**MEM_AW words, addresses above alias (upper bits ignored)
// PORTS
//  hclk        in   1           clock; every register updates on its rising edge
//  hreset      in   1           synchronous reset, active-high
//  hsel        in   1           slave select
//  haddr       in   ADDR_WIDTH  byte address (address phase)
//  htrans      in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite      in   1           1 = write
//  hsize       in   3           000 byte, 001 half, 010 word, others illegal
//  hburst      in   3           ignored (every beat is decoded on its own)
//  hprot       in   4           ignored
//  hwdata      in   DATA_WIDTH  write data (data phase)
//  hready      in   1           bus-level ready; an address phase is accepted only when it is high
//  hreadyout   out  1           slave ready
//  hresp       out  2           00 OKAY, 01 ERROR
//  hrdata      out  DATA_WIDTH  read data
//  sram_ce     out  1           SRAM chip enable
//  sram_we     out  1           1 = write, 0 = read
//  sram_addr   out  MEM_AW      SRAM word address = haddr[MEM_AW+1:2]
//  sram_be     out  4           byte enables for writes
//  sram_wdata  out  32          SRAM write data
//  sram_rdata  in   32          SRAM read data, valid the cycle after a read with sram_ce=1
// BEHAVIOUR
//  accept = hsel & hready & htrans[1]. illegal = hsize>2, or half with haddr[0]=1, or word with haddr[1:0]!=0.
//  be: byte -> 1<<haddr[1:0]; half -> 4'b0011<<haddr[1:0]; word -> 4'b1111.
//  FSM states: IDLE, WRITE, READ, RD_STALL, ERR1, ERR2. On any accept, the address, be and hwrite are latched.
//  Next state on accept: illegal -> ERR1; write -> WRITE; read -> READ, or RD_STALL if the current state is WRITE.
//  Without an accept, the states IDLE/WRITE/READ/ERR2 go to IDLE. RD_STALL -> READ. ERR1 -> ERR2 (no accept is
//  possible in either state because hreadyout is low).
//  The SRAM write port has priority over a read in the same cycle.
//  State outputs:
//   IDLE     hreadyout=1, hresp=00.
//   WRITE    hreadyout=1; sram_ce=1, we=1, latched addr/be, sram_wdata=hwdata (written in this data-phase cycle).
//   READ     hreadyout=1; hrdata=sram_rdata.
//   RD_STALL hreadyout=0; sram_ce=1, we=0, latched addr (read issued here, returned in READ).
//   ERR1     hreadyout=0, hresp=01.
//   ERR2     hreadyout=1, hresp=01.
//  Read issue: a legal read accept in any state except WRITE drives sram_ce=1, we=0, sram_addr from haddr in the same
//   (address-phase) cycle, so the data returns in READ with zero wait states.
//  Illegal transfers never touch the SRAM.
//  hrdata is 0 outside READ. sram_ce is 0 whenever no access is defined above.
//  IDLE and BUSY transfers, and transfers with hsel low, get an OKAY zero-wait response.
//  Read-after-write to the same address returns the newly written data (guaranteed by the stall).
//  Reset (synchronous, at any point including mid-stall or mid-error): state IDLE, hreadyout=1, hresp=00, hrdata=0,
//   sram_ce=0, and the latched address/be are cleared. A write whose data phase is cut by reset is dropped.
// STRUCTURE
//  Package ahb_sram_pkg holds: htrans_e (IDLE/BUSY/NONSEQ/SEQ), hsize_e, hresp_e (OKAY/ERROR), the state_e FSM enum,
//  and the DATA_WIDTH=32 constant.
//  Sub-module ahb_sram_decode (combinational): haddr[1:0], hsize -> be[3:0] and illegal. Everything else stays in the top.
// TESTING
//  - Word write 0xDEADBEEF @0x10, then IDLE, then read @0x10 -> write has zero waits; sram_be=F; read data phase returns
//    0xDEADBEEF with hreadyout=1.
//  - Back-to-back write 0x11223344 @0x20 then read @0x20 -> exactly one hreadyout=0 cycle (RD_STALL); hrdata=0x11223344.
//  - Byte writes 0xAA @0x31 and half-word 0xBBBB @0x32 -> sram_be 4'b0010 then 4'b1100; word read @0x30 returns
//    0xBBBBAAxx, with the low byte unchanged.
//  - Word read @0x42 (misaligned) and hsize=3'b011 -> hresp=01 for 2 cycles, hreadyout 0 then 1; no sram_ce pulse;
//    the next legal transfer is OKAY.
//  - hsel=1 with htrans=BUSY, and hready=0 with NONSEQ -> no SRAM access, OKAY, hreadyout=1.
//  - hreset asserted during RD_STALL -> the next cycle has hreadyout=1, hresp=00, sram_ce=0, state IDLE; a following
//    read of the earlier-written address still returns its data.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings, FSM states and data width for the AHB-to-SRAM slave.
package ahb_sram_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_sram_decode.sv
// Size/alignment decode: byte enables and illegal-transfer flag for one AHB beat.
module ahb_sram_decode
  import ahb_sram_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] hsize,
  output logic [3:0] be,
  output logic       illegal
);

  always_comb begin
    be      = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be      = 4'b0011 << addr_lo;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        be      = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave driving a 1-cycle-latency single-port SRAM; zero-wait except one stall on read-after-write.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_AW     = 14
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [MEM_AW-1:0]     sram_addr,
  output logic [3:0]            sram_be,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q;
  logic [3:0]        be_q;
  logic              write_q;

  logic [3:0]        be;
  logic              illegal;
  logic              accept;
  logic              rd_issue;

  ahb_sram_decode u_decode (
    .addr_lo (haddr[1:0]),
    .hsize   (hsize),
    .be      (be),
    .illegal (illegal)
  );

  // Stall and first error cycle hold hreadyout low, so no address phase can land there.
  assign accept = hsel && hready && htrans[1]
                  && (state_q != ST_RD_STALL) && (state_q != ST_ERR1);

  // Reads go straight to the SRAM in their address phase unless the write port is busy.
  assign rd_issue = accept && !illegal && !hwrite && (state_q != ST_WRITE);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= haddr[MEM_AW+1:2];
        be_q    <= be;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = 4'b0000;
    sram_wdata = '0;

    case (state_q)
      ST_WRITE: begin
        sram_ce    = 1'b1;
        sram_we    = write_q;
        sram_addr  = addr_q;
        sram_be    = be_q;
        sram_wdata = hwdata;
      end
      ST_READ:     hrdata = sram_rdata;
      ST_RD_STALL: begin
        hreadyout = 1'b0;
        sram_ce   = 1'b1;
        sram_addr = addr_q;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase

    if (rd_issue) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b0;
      sram_addr = haddr[MEM_AW+1:2];
    end

    case (state_q)
      ST_RD_STALL: state_d = ST_READ;
      ST_ERR1:     state_d = ST_ERR2;
      default: begin
        if (!accept)                  state_d = ST_IDLE;
        else if (illegal)             state_d = ST_ERR1;
        else if (hwrite)              state_d = ST_WRITE;
        else if (state_q == ST_WRITE) state_d = ST_RD_STALL;
        else                          state_d = ST_READ;
      end
    endcase

    // A data phase cut by reset must not reach the SRAM.
    if (hreset) begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = '0;
      sram_ce   = 1'b0;
      sram_we   = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, htrans[0], haddr[ADDR_WIDTH-1:MEM_AW+2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: pipelined AHB master, SRAM device model and byte-level reference memory.
module tb_ahb_sram_slave;

  localparam int unsigned MEM_AW = 14;
  localparam int unsigned NBYTES = 2 ** (MEM_AW + 2);
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic              hreset, hsel, hwrite, hready, hready_block, hreadyout;
  logic [31:0]       haddr, hwdata, hrdata;
  logic [1:0]        htrans, hresp;
  logic [2:0]        hsize, hburst;
  logic [3:0]        hprot, sram_be;
  logic              sram_ce, sram_we;
  logic [MEM_AW-1:0] sram_addr;
  logic [31:0]       sram_wdata, sram_rdata;

  // Single slave on the bus: hready follows hreadyout unless a step forces it low.
  assign hready = hreadyout & ~hready_block;

  ahb_sram_slave #(.ADDR_WIDTH(32), .MEM_AW(MEM_AW)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM device with one-cycle read latency.
  logic [31:0] sram_mem [2**MEM_AW];
  logic        mem_clear;
  int          ce_count;
  always @(posedge hclk) begin
    if (mem_clear) begin
      for (int i = 0; i < 2**MEM_AW; i++) sram_mem[i] <= '0;
      sram_rdata <= '0;
      ce_count   <= 0;
    end else if (sram_ce) begin
      ce_count <= ce_count + 1;
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: flat byte memory, addresses wrap at the memory size.
  logic [7:0] ref_mem [NBYTES];

  int checks = 0, passes = 0, fails = 0;
  int p_kind = K_NONE, p_waits = 0, last_waits = 0, base;
  logic [31:0] p_addr = '0, p_wdata = '0, last_rdata = '0;
  logic [3:0]  p_be = '0, last_be = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd2) return 1'b1;
    return (addr % (32'd1 << size)) != 32'd0;
  endfunction

  function automatic logic [3:0] bytes_touched(input logic [2:0] size, input logic [31:0] addr);
    logic [3:0] m = 4'b0000;
    for (int i = 0; i < (1 << size); i++) m[(int'(addr[1:0]) + i) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[{addr[MEM_AW+1:2], 2'(b)}];
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[{addr[MEM_AW+1:2], 2'(b)}] = data[8*b +: 8];
  endtask

  // One bus slot: address phase of a new beat overlapped with the data phase of the pending one.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic blk);
    int   waits = 0;
    logic acc, ill;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hready_block = blk;
    hburst = 3'($urandom); hprot = 4'($urandom);
    hwdata = (p_kind == K_WR) ? p_wdata : $urandom;
    acc = sel && !blk && trans[1];
    ill = is_illegal(size, addr);
    @(negedge hclk);
    if (p_kind == K_WR) begin
      chk("wr_ce_we", 32'(sram_ce & sram_we), 32'd1);
      chk("wr_be", 32'(sram_be), 32'(p_be));
      chk("wr_addr", 32'(sram_addr), 32'(p_addr[MEM_AW+1:2]));
      last_be = sram_be;
    end
    while (!hreadyout && waits < 4) begin
      if (p_kind == K_ERR) chk("err1_resp", 32'(hresp), 32'd1);
      waits++;
      @(negedge hclk);
    end
    chk("ready", 32'(hreadyout), 32'd1);
    chk("waits", 32'(waits), 32'(p_waits));
    chk("resp", 32'(hresp), (p_kind == K_ERR) ? 32'd1 : 32'd0);
    if (p_kind == K_RD) begin
      chk("rdata", hrdata, ref_word(p_addr));
      last_rdata = hrdata;
    end else begin
      chk("rdata_zero", hrdata, 32'd0);
    end
    last_waits = waits;
    if (p_kind == K_WR) ref_write(p_addr, p_be, p_wdata);
    if (!acc) begin
      p_kind = K_NONE; p_waits = 0;
    end else if (ill) begin
      p_kind = K_ERR; p_waits = 1;
    end else if (wr) begin
      p_kind = K_WR; p_waits = 0; p_addr = addr; p_be = bytes_touched(size, addr); p_wdata = wdata;
    end else begin
      p_waits = (p_kind == K_WR) ? 1 : 0;
      p_kind = K_RD; p_addr = addr;
    end
    @(posedge hclk); #1;
  endtask

  task automatic idle();
    step(1'b0, T_IDLE, 1'b0, 3'd2, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;
    mem_clear = 1'b1; hreset = 1'b1; hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = 3'd2; haddr = '0; hwdata = '0; hburst = '0; hprot = '0; hready_block = 1'b0;
    repeat (2) @(posedge hclk);
    #1 mem_clear = 1'b0; hreset = 1'b0;
    @(negedge hclk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_sram_ce", 32'(sram_ce), 32'd0);
    @(posedge hclk); #1;

    // Word write, gap, read back.
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    idle();
    chk("t1_be", 32'(last_be), 32'hF);
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    idle();
    chk("t1_data", last_rdata, 32'hDEADBEEF);
    chk("t1_waits", 32'(last_waits), 32'd0);

    // Read directly after write: one stall cycle.
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0);
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0);
    idle();
    chk("t2_waits", 32'(last_waits), 32'd1);
    chk("t2_data", last_rdata, 32'h11223344);

    // Sub-word writes merge into an existing word.
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h30, 32'h55667788, 1'b0);
    step(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h31, 32'hAAAAAAAA, 1'b0);
    step(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h32, 32'hBBBBBBBB, 1'b0);
    chk("t3_be_byte", 32'(last_be), 32'b0010);
    idle();
    chk("t3_be_half", 32'(last_be), 32'b1100);
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h30, 32'd0, 1'b0);
    idle();
    chk("t3_data", last_rdata, 32'hBBBBAA88);

    // Illegal transfers: two-cycle ERROR, SRAM untouched, then a normal transfer.
    base = ce_count;
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h42, 32'd0, 1'b0);
    step(1'b1, T_NSEQ, 1'b1, 3'd3, 32'h44, 32'h12345678, 1'b0);
    idle();
    chk("t4_err_waits", 32'(last_waits), 32'd1);
    chk("t4_no_sram", 32'(ce_count - base), 32'd0);
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h44, 32'hCAFEF00D, 1'b0);
    idle();

    // BUSY and NONSEQ with hready low are ignored.
    base = ce_count;
    step(1'b1, T_BUSY, 1'b1, 3'd2, 32'h10, 32'h0BADBAD0, 1'b0);
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'h0BADBAD0, 1'b1);
    idle();
    chk("t5_no_sram", 32'(ce_count - base), 32'd0);

    // Reset landing in the read stall.
    step(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h50, 32'h600DF00D, 1'b0);
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h50, 32'd0, 1'b0);
    hsel = 1'b0; htrans = T_IDLE;
    @(negedge hclk);
    chk("t6_stall", 32'(hreadyout), 32'd0);
    hreset = 1'b1;
    @(posedge hclk); #1 hreset = 1'b0;
    @(negedge hclk);
    chk("t6_hreadyout", 32'(hreadyout), 32'd1);
    chk("t6_hresp", 32'(hresp), 32'd0);
    chk("t6_sram_ce", 32'(sram_ce), 32'd0);
    chk("t6_hrdata", hrdata, 32'd0);
    p_kind = K_NONE; p_waits = 0;
    @(posedge hclk); #1;
    step(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h50, 32'd0, 1'b0);
    idle();
    chk("t6_data", last_rdata, 32'h600DF00D);

    // Random traffic, including aliased addresses above the memory size.
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [2:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 32'h0001_0000 * $urandom_range(1, 3);
      if (r == 3) begin
        if ($urandom_range(0, 1) == 0) sz = 3'($urandom_range(3, 7));
        else begin sz = 3'($urandom_range(1, 2)); a = a | 32'd1; end
      end else begin
        a = a & ~((32'd1 << sz) - 32'd1);
      end
      case (r)
        0:       step(1'b0, 2'($urandom), 1'($urandom), sz, a, $urandom, 1'b0);
        1:       step(1'b1, T_BUSY, 1'($urandom), sz, a, $urandom, 1'b0);
        2:       step(1'b1, T_NSEQ, 1'($urandom), sz, a, $urandom, 1'b1);
        default: step(1'b1, 2'($urandom_range(2, 3)), 1'($urandom), sz, a, $urandom, 1'b0);
      endcase
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
